uncached_store_buffer: RTL and testbench
========================================

// Module: uncached_store_buffer
// PURPOSE
//  Posted-write FIFO between the MEM-stage CPU store port and the uncached AXI
//  write engine. Uncached stores retire in one cycle without waiting for the
//  AXI B/W handshakes. Entries drain in order through the engine's cpu_*
//  interface (req/grnt, AW/W/B live inside the engine).
//  Uncached loads and SYNC are held off until the buffer is empty, which keeps
//  program order to devices.
// PARAMETERS
//  DEPTH  4  entries; power of two, 2..16
//  PTR_W  2  log2(DEPTH)
// PORTS
//  clk                  in   1      clock, all state on posedge
//  rst_n                in   1      asynchronous reset, active low
//  cpu_uncached         in   1      MEM access is uncached
//  cpu_we               in   1      MEM access is a store
//  cpu_re               in   1      MEM access is a load
//  cpu_sync             in   1      SYNC/ERET drain request
//  cpu_addr             in   32     byte address
//  cpu_byte_enable      in   4      byte lanes of the store
//  cpu_wdata            in   32     store data, lane-aligned
//  cpu_Stall            out  1      hold MEM (and PC) this cycle
//  sb_empty             out  1      no entries pending
//  sb_count             out  PTR_W+1  entries pending, 0..DEPTH
//  st_uncached          out  1      to engine: equals st_we
//  st_we                out  1      to engine: head entry valid
//  st_addr              out  32     head address, unmodified
//  st_byte_enable       out  4      head byte enables
//  st_wdata             out  32     head data
//  st_Stall             in   1      engine busy; 0 while st_we=1 means head written
// BEHAVIOUR
//  Storage and pointers
//  - Entry = {addr[31:0], be[3:0], data[31:0]}. wr_ptr/rd_ptr are PTR_W bits
//    and wrap modulo DEPTH. count is PTR_W+1 bits.
//  - full = (count==DEPTH), empty = (count==0).
//  Push and pop
//  - push = cpu_uncached & cpu_we & ~full.
//    Write mem[wr_ptr], then wr_ptr++.
//  - pop = st_we & ~st_Stall.
//    rd_ptr++.
//  - count += push - pop. A simultaneous push and pop leaves count unchanged.
//  Engine-side outputs
//  - st_we = ~empty. st_addr, st_byte_enable and st_wdata come from mem[rd_ptr].
//  - They change only on a pop, so they stay stable while st_Stall=1.
//  - After a pop the next head is presented in the following cycle with no idle
//    cycle. The engine restarts from IDLE on its own.
//  - When the pop empties the buffer, st_we is 0 in the next cycle, so the
//    engine never re-issues a written entry.
//  Stall to the CPU (combinational from registered state and current inputs)
//  - cpu_Stall = (cpu_uncached & cpu_we & full)
//              | (cpu_uncached & cpu_re & ~empty)
//              | (cpu_sync & ~empty).
//  - A full buffer stalls a store even if a pop happens in the same cycle.
//    This keeps st_Stall off the cpu_Stall path; the store is accepted in the
//    next cycle.
//  - An uncached load with empty=1 is not stalled here. The engine-side loader
//    handles it.
//  - Cached accesses are never stalled.
//  - The ordering rule reads the registered empty flag. A store pushed in cycle
//    N makes a load in cycle N+1 stall.
//  Reset (rst_n=0, asynchronous)
//  - wr_ptr, rd_ptr and count are cleared. Memory contents are not cleared.
//  - st_we=0 and st_uncached=0. sb_empty=1 and sb_count=0.
//  - cpu_Stall=0 unless cpu_sync or an uncached load is asserted; both then
//    see empty, so cpu_Stall=0.
//  - Reset during a drain discards pending entries. The engine is reset by the
//    same rst_n.
//  - No push is accepted while rst_n=0.
// TESTING
//  1. Single store: sw 0xDEADBEEF to 0xBFAF8000, be=4'hF. Result: no
//     cpu_Stall, next cycle st_we=1 with that addr/data, pop when st_Stall
//     falls, then sb_empty=1.
//  2. Burst: 5 back-to-back stores with DEPTH=4 and st_Stall held high.
//     Result: stores 1-4 accepted and store 5 stalled. Hold st_Stall low for 1
//     cycle: one pop, store 5 accepted the next cycle, FIFO order preserved on
//     st_addr.
//  3. Ordering: store to 0xBFD0F000, then uncached load in the next cycle.
//     Result: load stalled until the cycle after the pop, then cpu_Stall=0.
//  4. Simultaneous push and pop at count=2. Result: count stays 2, the head
//     advances and the new tail is written at the wrapped wr_ptr (for example
//     3 to 0).
//  5. Reset while count=3 and st_Stall=1. Result: st_we=0 and sb_count=0
//     immediately, with no entry emitted after reset release.
//  6. cpu_sync with count=1. Result: cpu_Stall=1 until the pop, then 0. A
//     cached store during the stall is not pushed.

Source files
------------

// File: rtl/uncached_store_buffer_if.sv
// rtl/uncached_store_buffer_if.sv - store-buffer to uncached write engine head-entry bus
interface uncached_store_buffer_if;
    logic        st_uncached;
    logic        st_we;
    logic [31:0] st_addr;
    logic [3:0]  st_byte_enable;
    logic [31:0] st_wdata;
    logic        st_Stall;

    // Buffer side presents the head entry and watches the engine's busy flag.
    modport master (
        output st_uncached,
        output st_we,
        output st_addr,
        output st_byte_enable,
        output st_wdata,
        input  st_Stall
    );

    // Engine side consumes the head entry and reports when it is busy.
    modport slave (
        input  st_uncached,
        input  st_we,
        input  st_addr,
        input  st_byte_enable,
        input  st_wdata,
        output st_Stall
    );
endinterface

// File: rtl/uncached_store_buffer.sv
// rtl/uncached_store_buffer.sv - posted-write FIFO between CPU uncached stores and the AXI write engine
module uncached_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_uncached,
    input  logic                  cpu_we,
    input  logic                  cpu_re,
    input  logic                  cpu_sync,
    input  logic [31:0]           cpu_addr,
    input  logic [3:0]            cpu_byte_enable,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_Stall,
    output logic                  sb_empty,
    output logic [PTR_W:0]        sb_count,
    uncached_store_buffer_if.master st
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]    memAddr [DEPTH];
    logic [3:0]     memBe   [DEPTH];
    logic [31:0]    memData [DEPTH];

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // A held reset must not sneak an entry into storage.
    assign push = rst_n & cpu_uncached & cpu_we & ~full;
    assign pop  = st.st_we & ~st.st_Stall;

    // Stall decision uses only registered full/empty so st_Stall never reaches cpu_Stall.
    assign cpu_Stall = (cpu_uncached & cpu_we & full)
                     | (cpu_uncached & cpu_re & ~empty)
                     | (cpu_sync & ~empty);

    assign sb_empty = empty;
    assign sb_count = count;

    // Head entry is read straight out of storage; it only moves when rdPtr advances.
    assign st.st_we          = ~empty;
    assign st.st_uncached    = ~empty;
    assign st.st_addr        = memAddr[rdPtr];
    assign st.st_byte_enable = memBe[rdPtr];
    assign st.st_wdata       = memData[rdPtr];

    // Entry storage: written on push, never cleared (pointers define validity).
    always_ff @(posedge clk) begin
        if (push) begin
            memAddr[wrPtr] <= cpu_addr;
            memBe[wrPtr]   <= cpu_byte_enable;
            memData[wrPtr] <= cpu_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; reset drops any pending entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uncached_store_buffer.sv
// tb/tb_uncached_store_buffer.sv - directed self-checking bench for uncached_store_buffer
module tb_uncached_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        cpu_uncached;
    logic        cpu_we;
    logic        cpu_re;
    logic        cpu_sync;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byte_enable;
    logic [31:0] cpu_wdata;
    logic        cpu_Stall;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int nComp = 0;
    int nFail = 0;

    uncached_store_buffer_if sbif ();

    uncached_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_uncached    (cpu_uncached),
        .cpu_we          (cpu_we),
        .cpu_re          (cpu_re),
        .cpu_sync        (cpu_sync),
        .cpu_addr        (cpu_addr),
        .cpu_byte_enable (cpu_byte_enable),
        .cpu_wdata       (cpu_wdata),
        .cpu_Stall       (cpu_Stall),
        .sb_empty        (sb_empty),
        .sb_count        (sb_count),
        .st              (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        cpu_uncached    = 1'b0;
        cpu_we          = 1'b0;
        cpu_re          = 1'b0;
        cpu_sync        = 1'b0;
        cpu_addr        = 32'h0;
        cpu_byte_enable = 4'h0;
        cpu_wdata       = 32'h0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cpu_uncached    = 1'b1;
        cpu_we          = 1'b1;
        cpu_re          = 1'b0;
        cpu_sync        = 1'b0;
        cpu_addr        = a;
        cpu_byte_enable = be;
        cpu_wdata       = d;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        sbif.st_Stall = 1'b1;

        // Reset state, with a push attempt, a sync and an uncached load all asserted.
        store(32'h1111_0000, 32'h2222_0000, 4'hF);
        cpu_re   = 1'b1;
        cpu_sync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_st_we", {31'b0, sbif.st_we}, 32'd0);
        chk("rst_st_uncached", {31'b0, sbif.st_uncached}, 32'd0);
        chk("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
        chk("rst_sb_count", {29'b0, sb_count}, 32'd0);
        chk("rst_cpu_stall", {31'b0, cpu_Stall}, 32'd0);
        idle();
        rst_n = 1'b1;

        // 1. Single store, popped when st_Stall falls.
        tick();
        store(32'hBFAF_8000, 32'hDEAD_BEEF, 4'hF);
        settle();
        chk("t1_no_stall", {31'b0, cpu_Stall}, 32'd0);
        tick();
        idle();
        settle();
        chk("t1_st_we", {31'b0, sbif.st_we}, 32'd1);
        chk("t1_st_uncached", {31'b0, sbif.st_uncached}, 32'd1);
        chk("t1_st_addr", sbif.st_addr, 32'hBFAF_8000);
        chk("t1_st_wdata", sbif.st_wdata, 32'hDEAD_BEEF);
        chk("t1_st_be", {28'b0, sbif.st_byte_enable}, 32'hF);
        chk("t1_count", {29'b0, sb_count}, 32'd1);
        tick();
        chk("t1_hold_addr", sbif.st_addr, 32'hBFAF_8000);
        sbif.st_Stall = 1'b0;
        tick();
        sbif.st_Stall = 1'b1;
        settle();
        chk("t1_empty", {31'b0, sb_empty}, 32'd1);
        chk("t1_st_we_off", {31'b0, sbif.st_we}, 32'd0);

        // 2. Burst of five with DEPTH=4: fifth stalls until one pop frees a slot.
        for (int i = 0; i < 5; i++) begin
            store(32'h1000_0000 + 32'(i * 4), 32'h0000_00A0 + 32'(i), 4'h3);
            settle();
            chk($sformatf("t2_stall_%0d", i), {31'b0, cpu_Stall}, (i < 4) ? 32'd0 : 32'd1);
            if (i < 4) tick();
        end
        chk("t2_count_full", {29'b0, sb_count}, 32'd4);
        chk("t2_head0", sbif.st_addr, 32'h1000_0000);
        sbif.st_Stall = 1'b0;
        settle();
        chk("t2_stall_with_pop", {31'b0, cpu_Stall}, 32'd1);
        tick();
        sbif.st_Stall = 1'b1;
        settle();
        chk("t2_count_after_pop", {29'b0, sb_count}, 32'd3);
        chk("t2_head1", sbif.st_addr, 32'h1000_0004);
        chk("t2_store5_go", {31'b0, cpu_Stall}, 32'd0);
        tick();
        idle();
        settle();
        chk("t2_count_refull", {29'b0, sb_count}, 32'd4);
        sbif.st_Stall = 1'b0;
        for (int j = 1; j < 5; j++) begin
            chk($sformatf("t2_order_%0d", j), sbif.st_addr, 32'h1000_0000 + 32'(j * 4));
            chk($sformatf("t2_data_%0d", j), sbif.st_wdata, 32'h0000_00A0 + 32'(j));
            tick();
        end
        sbif.st_Stall = 1'b1;
        settle();
        chk("t2_drained", {31'b0, sb_empty}, 32'd1);

        // 3. Uncached load right behind a store waits until the cycle after the pop.
        store(32'hBFD0_F000, 32'h0000_0055, 4'h1);
        tick();
        idle();
        cpu_uncached = 1'b1;
        cpu_re       = 1'b1;
        settle();
        chk("t3_load_stall_a", {31'b0, cpu_Stall}, 32'd1);
        tick();
        chk("t3_load_stall_b", {31'b0, cpu_Stall}, 32'd1);
        sbif.st_Stall = 1'b0;
        settle();
        chk("t3_load_stall_popcycle", {31'b0, cpu_Stall}, 32'd1);
        tick();
        sbif.st_Stall = 1'b1;
        settle();
        chk("t3_load_go", {31'b0, cpu_Stall}, 32'd0);
        cpu_uncached = 1'b0;
        settle();
        chk("t3_cached_load", {31'b0, cpu_Stall}, 32'd0);
        idle();

        // 4. Pointers now at 3; fill four, pop two, then push+pop together at count=2.
        for (int i = 0; i < 4; i++) begin
            store(32'h2000_0000 + 32'(i), 32'hC000_0000 + 32'(i), 4'hF);
            tick();
        end
        idle();
        sbif.st_Stall = 1'b0;
        tick();
        tick();
        settle();
        chk("t4_count2", {29'b0, sb_count}, 32'd2);
        chk("t4_head_c2", sbif.st_addr, 32'h2000_0002);
        store(32'h2000_0004, 32'hC000_0004, 4'hF);
        tick();
        idle();
        sbif.st_Stall = 1'b1;
        settle();
        chk("t4_count_same", {29'b0, sb_count}, 32'd2);
        chk("t4_head_c3", sbif.st_addr, 32'h2000_0003);
        sbif.st_Stall = 1'b0;
        tick();
        settle();
        chk("t4_tail_wrapped", sbif.st_addr, 32'h2000_0004);
        chk("t4_tail_data", sbif.st_wdata, 32'hC000_0004);
        tick();
        sbif.st_Stall = 1'b1;
        settle();
        chk("t4_empty", {31'b0, sb_empty}, 32'd1);

        // 5. Reset with three pending entries clears immediately and emits nothing.
        for (int i = 0; i < 3; i++) begin
            store(32'h3000_0000 + 32'(i), 32'h0, 4'hF);
            tick();
        end
        chk("t5_count3", {29'b0, sb_count}, 32'd3);
        rst_n = 1'b0;
        settle();
        chk("t5_async_we", {31'b0, sbif.st_we}, 32'd0);
        chk("t5_async_count", {29'b0, sb_count}, 32'd0);
        tick();
        chk("t5_no_push_in_reset", {29'b0, sb_count}, 32'd0);
        idle();
        rst_n = 1'b1;
        sbif.st_Stall = 1'b0;
        tick();
        tick();
        chk("t5_post_we", {31'b0, sbif.st_we}, 32'd0);
        chk("t5_post_empty", {31'b0, sb_empty}, 32'd1);
        sbif.st_Stall = 1'b1;

        // 6. SYNC with one entry stalls until the pop; a cached store is not buffered.
        store(32'h4000_0000, 32'h0000_0066, 4'hF);
        tick();
        idle();
        cpu_sync = 1'b1;
        cpu_we   = 1'b1;
        settle();
        chk("t6_sync_stall", {31'b0, cpu_Stall}, 32'd1);
        tick();
        chk("t6_cached_not_pushed", {29'b0, sb_count}, 32'd1);
        sbif.st_Stall = 1'b0;
        settle();
        chk("t6_sync_stall_popcycle", {31'b0, cpu_Stall}, 32'd1);
        tick();
        sbif.st_Stall = 1'b1;
        settle();
        chk("t6_sync_go", {31'b0, cpu_Stall}, 32'd0);
        chk("t6_count0", {29'b0, sb_count}, 32'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
